// File: rtl/irq_controller.sv
// Four-source interrupt controller: two sticky MMU faults and two maskable level
// requests, fixed priority, with a REQ/ack/SERVICE/eoi handshake toward the CPU.
module irq_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       prot_fault,
    input  logic       page_fault,
    input  logic       uart_irq,
    input  logic       timer_irq,
    input  logic       mask_we,
    input  logic [1:0] mask_wdata,
    input  logic       irq_ack,
    input  logic       irq_eoi,
    output logic       intr,
    output logic [2:0] irq_nr,
    output logic       in_service,
    output logic [1:0] mask_q,
    output logic [3:0] pending
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0] state_r;
    logic [1:0] fault_pend_r;   // bit0 prot, bit1 page
    logic [1:0] samp_r;         // bit0 uart, bit1 timer
    logic [1:0] elig_r;         // bit0 uart, bit1 timer

    logic [1:0] state_s;
    logic       intr_s;
    logic [2:0] irq_nr_s;
    logic       in_service_s;
    logic [1:0] fault_clr_s;
    logic [2:0] sel_s;

    // Lowest set bit wins; result is the 1-based source number, 0 when idle.
    function automatic logic [2:0] prio_encode(input logic [3:0] req);
        logic [2:0] nr;
        if (req[0]) begin
            nr = 3'd1;
        end else if (req[1]) begin
            nr = 3'd2;
        end else if (req[2]) begin
            nr = 3'd3;
        end else if (req[3]) begin
            nr = 3'd4;
        end else begin
            nr = 3'd0;
        end
        return nr;
    endfunction

    assign pending = {elig_r, fault_pend_r};
    assign sel_s   = prio_encode(pending);

    // Next-state and output decode for the request/service handshake.
    always_comb begin
        state_s      = state_r;
        intr_s       = intr;
        irq_nr_s     = irq_nr;
        in_service_s = in_service;
        fault_clr_s  = 2'b00;
        case (state_r)
            ST_IDLE: begin
                in_service_s = 1'b0;
                if (sel_s != 3'd0) begin
                    state_s  = ST_REQ;
                    intr_s   = 1'b1;
                    irq_nr_s = sel_s;
                end else begin
                    intr_s   = 1'b0;
                    irq_nr_s = 3'd0;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    // The number already shown to the CPU is what gets serviced.
                    state_s      = ST_SERVICE;
                    intr_s       = 1'b0;
                    in_service_s = 1'b1;
                    if (irq_nr == 3'd1) begin
                        fault_clr_s = 2'b01;
                    end else if (irq_nr == 3'd2) begin
                        fault_clr_s = 2'b10;
                    end else begin
                        fault_clr_s = 2'b00;
                    end
                end else if (sel_s != 3'd0) begin
                    intr_s   = 1'b1;
                    irq_nr_s = sel_s;
                end else begin
                    state_s  = ST_IDLE;
                    intr_s   = 1'b0;
                    irq_nr_s = 3'd0;
                end
            end
            ST_SERVICE: begin
                intr_s = 1'b0;
                if (irq_eoi) begin
                    state_s      = ST_IDLE;
                    irq_nr_s     = 3'd0;
                    in_service_s = 1'b0;
                end else begin
                    in_service_s = 1'b1;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                intr_s       = 1'b0;
                irq_nr_s     = 3'd0;
                in_service_s = 1'b0;
            end
        endcase
    end

    // State, outputs, fault latches, level sampling and mask register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            intr         <= 1'b0;
            irq_nr       <= 3'd0;
            in_service   <= 1'b0;
            mask_q       <= 2'b11;
            fault_pend_r <= 2'b00;
            samp_r       <= 2'b00;
            elig_r       <= 2'b00;
        end else begin
            state_r      <= state_s;
            intr         <= intr_s;
            irq_nr       <= irq_nr_s;
            in_service   <= in_service_s;
            // A fault pulse coinciding with its own ack re-sets the latch.
            fault_pend_r <= (fault_pend_r & ~fault_clr_s) | {page_fault, prot_fault};
            samp_r       <= {timer_irq, uart_irq};
            // Eligibility is registered, so a level reaches intr two edges after sampling.
            elig_r       <= samp_r & ~mask_q;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end else begin
                mask_q <= mask_q;
            end
        end
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port prot_fault, input, 1 bit: protection fault pulse from MMU, priority 1 (highest).
REQ-004 The block SHALL have the port page_fault, input, 1 bit: page fault pulse from MMU, priority 2.
REQ-005 The block SHALL have the port uart_irq, input, 1 bit: UART level request, priority 3.
REQ-006 The block SHALL have the port timer_irq, input, 1 bit: timer level request, priority 4 (lowest).
REQ-007 The block SHALL have the port mask_we, input, 1 bit: write strobe for the external mask register.
REQ-008 The block SHALL have the port mask_wdata, input, 2 bits: new mask value; bit0 masks uart_irq, bit1 masks timer_irq; 1 = masked.
REQ-009 The block SHALL have the port irq_ack, input, 1 bit: CPU accepts the request shown on irq_nr.
REQ-010 The block SHALL have the port irq_eoi, input, 1 bit: CPU signals end of handler.
REQ-011 The block SHALL have the port intr, output, 1 bit: interrupt request to CPU, registered.
REQ-012 The block SHALL have the port irq_nr, output, 3 bits: 1..4 = source number, 0 = none, registered.
REQ-013 The block SHALL have the port in_service, output, 1 bit: high while in SERVICE.
REQ-014 The block SHALL have the port mask_q, output, 2 bits: current mask register.
REQ-015 The block SHALL have the port pending, output, 4 bits: eligible sources {timer,uart,page,prot}, bit0 = prot.

Function
REQ-016 Fault inputs SHALL be captured into sticky latches fault_pend[1:0] on any clock edge where high; faults are never masked.
REQ-017 uart_irq/timer_irq SHALL be registered once (sample stage); eligibility = sampled level AND NOT mask bit; not latched, so sources hold until serviced.
REQ-018 pending SHALL equal {timer_elig, uart_elig, page_pend, prot_pend}; selection SHALL be fixed priority prot > page > uart > timer, encoded 1/2/3/4.
REQ-019 The FSM SHALL have the states IDLE, REQ, SERVICE.
REQ-020 In IDLE, when any pending bit is set, the FSM SHALL go to REQ at the next edge, setting intr=1 and irq_nr=selected source.
REQ-021 In REQ, irq_nr SHALL be re-evaluated every cycle, so a higher-priority arrival replaces it; if nothing remains eligible (level dropped or masked), the FSM SHALL return to IDLE with intr=0 and irq_nr=0.
REQ-022 In REQ, on irq_ack, the FSM SHALL go to SERVICE with intr=0, irq_nr held at the value presented in the ack cycle, and in_service=1; acking 1 or 2 SHALL clear the matching fault latch.
REQ-023 In SERVICE, new requests SHALL only accumulate (no nesting) and intr SHALL stay 0.
REQ-024 In SERVICE, on irq_eoi, the FSM SHALL go to IDLE with irq_nr=0 and in_service=0; at least one IDLE cycle SHALL separate SERVICE and the next intr.
REQ-025 irq_ack outside REQ and irq_eoi outside SERVICE SHALL be ignored; ack and eoi in the same cycle SHALL act as ack only.
REQ-026 A fault pulse in the same cycle as the ack clearing that fault SHALL win: the latch stays set.
REQ-027 A mask write SHALL take effect at the next edge; eligibility SHALL use mask_q.
REQ-028 Latency: fault high at edge N -> intr=1 after edge N+1; external level high at edge N -> intr=1 after edge N+2.

Reset
REQ-029 When reset_n=0 at an edge: state=IDLE, intr=0, irq_nr=0, in_service=0, mask_q=2'b11, fault latches=0, sample regs=0; reset SHALL override all other inputs, including mid-REQ or mid-SERVICE.

Verification
REQ-030 After reset, uart_irq=1 SHALL give no intr; write mask 2'b00 -> intr=1, irq_nr=3 within 3 edges.
REQ-031 timer and uart high, mask 0 -> irq_nr=3; ack, eoi, uart dropped -> irq_nr=4 after the IDLE gap.
REQ-032 In REQ with irq_nr=4, a one-cycle prot_fault pulse -> irq_nr=1 next cycle; ack -> prot latch cleared, in_service=1.
REQ-033 page_fault pulse during SERVICE -> no intr until eoi, then intr=1, irq_nr=2.
REQ-034 In REQ with irq_nr=3, uart_irq dropped before ack -> return to IDLE, intr=0, irq_nr=0.
REQ-035 reset_n=0 during SERVICE with fault latched -> all outputs at reset values and pending=0 next cycle.
